hazard_ctrl: RTL and testbench

- Pipeline control for the 5-stage RV32I core; consumes the register specifiers and control bits that the decode/execute pipeline registers deliver.
- Drives stall, flush and forwarding selects back into the IF/ID, ID/EX and EX/MEM registers.
- Tracks a small event FSM (run / load-use / redirect / memory wait) and keeps saturating performance counters for stall cycles and flush events.

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the RV32I pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDUSE = 2'd1,
        REDIR = 2'd2,
        MWAIT = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; the younger MEM result wins over WB.
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic             wen_rfM,
    input  logic             wen_rfW,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (wen_rfM && (rdM != '0) && (rdM == rsE))
            fwd = FWD_MEM;
        else if (wen_rfW && (rdW != '0) && (rdW == rsE))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage core, with event FSM and
// saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic [REG_W-1:0] rs1E,
    input  logic [REG_W-1:0] rs2E,
    input  logic [REG_W-1:0] rdE,
    input  logic             wen_rfE,
    input  logic             loadE,
    input  logic             pc_srcE,
    input  logic [REG_W-1:0] rdM,
    input  logic [REG_W-1:0] rdW,
    input  logic             wen_rfM,
    input  logic             wen_rfW,
    input  logic             en_dmemM,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state, next_state;
    logic       mem_wait, redirect, load_use;
    logic [1:0] fwd_a, fwd_b;

    assign mem_wait = en_dmemM & ~dmem_ready;
    assign redirect = pc_srcE;
    assign load_use = loadE & wen_rfE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

    // A memory wait freezes EX, so any redirect/load-use there is retried later.
    always_comb begin
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        next_state = RUN;
        if (mem_wait) begin
            stallF     = 1'b1;
            stallD     = 1'b1;
            stallE     = 1'b1;
            stallM     = 1'b1;
            next_state = MWAIT;
        end else if (redirect) begin
            flushD     = 1'b1;
            flushE     = 1'b1;
            next_state = REDIR;
        end else if (load_use) begin
            stallF     = 1'b1;
            stallD     = 1'b1;
            flushE     = 1'b1;
            next_state = LDUSE;
        end
        if (!rst_n) begin
            stallF = 1'b0;
            stallD = 1'b0;
            stallE = 1'b0;
            stallM = 1'b0;
            flushD = 1'b0;
            flushE = 1'b0;
        end
    end

    fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rsE(rs1E), .rdM(rdM), .rdW(rdW),
        .wen_rfM(wen_rfM), .wen_rfW(wen_rfW), .fwd(fwd_a)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rsE(rs2E), .rdM(rdM), .rdW(rdW),
        .wen_rfM(wen_rfM), .wen_rfW(wen_rfW), .fwd(fwd_b)
    );

    assign forwardAE = rst_n ? fwd_a : FWD_RF;
    assign forwardBE = rst_n ? fwd_b : FWD_RF;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallF && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: priorities, forwarding, FSM, counters, reset.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             wen_rfE, loadE, pc_srcE, wen_rfM, wen_rfW;
    logic             en_dmemM, dmem_ready, cnt_clr;
    logic             stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]       forwardAE, forwardBE, state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .wen_rfE(wen_rfE), .loadE(loadE), .pc_srcE(pc_srcE),
        .rdM(rdM), .rdW(rdW), .wen_rfM(wen_rfM), .wen_rfW(wen_rfW),
        .en_dmemM(en_dmemM), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .state_o(state_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        wen_rfE = 0; loadE = 0; pc_srcE = 0; wen_rfM = 0; wen_rfW = 0;
        en_dmemM = 0; dmem_ready = 1; cnt_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // reset held with a memory wait and a forwarding match on the inputs
        en_dmemM = 1; dmem_ready = 0; wen_rfM = 1; rdM = 7; rs1E = 7;
        #2;
        chk("rst_stallF", stallF, 0);
        chk("rst_stallM", stallM, 0);
        chk("rst_fwdA", forwardAE, 2'b00);
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // release mid-cycle while mem_wait is active
        rst_n = 1'b1;
        #1;
        chk("rel_stallF", stallF, 1);
        chk("rel_fwdA_mwait", forwardAE, 2'b10);
        chk("rel_state_run", state_o, 0);
        tick();
        chk("rel_state_mwait", state_o, 3);
        chk("rel_stall_cnt", stall_cnt, 1);
        idle();
        tick();
        chk("mw_exit_state", state_o, 0);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("clr_stall_cnt", stall_cnt, 0);

        // load-use
        loadE = 1; wen_rfE = 1; rdE = 5; rs1D = 5;
        #1;
        chk("lu_stallF", stallF, 1);
        chk("lu_stallD", stallD, 1);
        chk("lu_flushE", flushE, 1);
        chk("lu_flushD", flushD, 0);
        chk("lu_stallE", stallE, 0);
        tick();
        chk("lu_state", state_o, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_flush_cnt", flush_cnt, 1);

        // redirect beats load-use
        pc_srcE = 1;
        #1;
        chk("rd_flushD", flushD, 1);
        chk("rd_flushE", flushE, 1);
        chk("rd_stallF", stallF, 0);
        tick();
        chk("rd_state", state_o, 2);
        chk("rd_flush_cnt", flush_cnt, 2);
        chk("rd_stall_cnt", stall_cnt, 1);

        // memory wait defers a redirect for 3 cycles
        idle();
        pc_srcE = 1; en_dmemM = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stallF", stallF, 1);
            chk("mw_stallM", stallM, 1);
            chk("mw_stallE", stallE, 1);
            chk("mw_flushD", flushD, 0);
            tick();
        end
        chk("mw_state", state_o, 3);
        chk("mw_stall_cnt", stall_cnt, 4);
        dmem_ready = 1;
        #1;
        chk("mw_rel_flushD", flushD, 1);
        chk("mw_rel_flushE", flushE, 1);
        chk("mw_rel_stallF", stallF, 0);
        tick();
        chk("mw_rel_state", state_o, 2);
        chk("mw_rel_flush_cnt", flush_cnt, 3);

        // forwarding
        idle();
        rdM = 7; rdW = 7; wen_rfM = 1; wen_rfW = 1; rs1E = 7; rs2E = 0;
        #1;
        chk("fwd_A_mem", forwardAE, 2'b10);
        chk("fwd_B_rf", forwardBE, 2'b00);
        wen_rfM = 0; rs2E = 7;
        #1;
        chk("fwd_A_wb", forwardAE, 2'b01);
        chk("fwd_B_wb", forwardBE, 2'b01);
        wen_rfM = 1; rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
        #1;
        chk("fwd_x0", forwardAE, 2'b00);

        // x0 load is never a hazard
        idle();
        loadE = 1; wen_rfE = 1; rdE = 0; rs1D = 0;
        #1;
        chk("x0_stallF", stallF, 0);
        chk("x0_flushE", flushE, 0);
        tick();
        chk("x0_state", state_o, 0);

        // saturation and clear
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        rdE = 3; rs2D = 3;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", stall_cnt, 15);
        chk("sat_flush_cnt", flush_cnt, 15);
        cnt_clr = 1;
        tick();
        chk("clr_pri_stall", stall_cnt, 0);
        chk("clr_pri_flush", flush_cnt, 0);
        cnt_clr = 0;
        tick();
        chk("post_clr_stall", stall_cnt, 1);
        chk("post_clr_state", state_o, 1);

        // async reset mid-stall
        rst_n = 1'b0;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        chk("arst_flush_cnt", flush_cnt, 0);
        chk("arst_stallF", stallF, 0);
        chk("arst_flushE", flushE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
